// File: rtl/uart_tx_arbiter_if.sv
// Bundle between uart_tx_arbiter, its byte-stream requesters and the uart_tx
// serializer.
//   req_valid/req_data/req_last : requester byte offer (requester i on data[8*i+7:8*i])
//   req_ready                   : one-hot byte-accept strobe back to the requesters
//   tx_start/tx_data/tx_ready   : handshake with uart_tx
//   grant_id/busy/pkt_abort     : arbitration status
// slave  : arbiter side.
// master : requesters + uart_tx + status observer side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic                 pkt_abort;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_start, tx_data, grant_id, busy, pkt_abort
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_start, tx_data, grant_id, busy, pkt_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer among NUM_REQ byte-stream
// requesters. Round-robin arbitration at packet granularity: the granted
// requester keeps the UART until a byte flagged last has been sent, so packets
// never interleave. A granted requester that leaves valid low for GAP_TIMEOUT
// SEND cycles mid-packet loses the grant (pkt_abort pulse).
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : uart_tx_arbiter_if.slave (requester handshake, uart_tx handshake,
//          grant_id / busy / pkt_abort status)
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(GAP_TIMEOUT);

  typedef enum logic [1:0] {ARB, SEND, WAIT_BUSY, WAIT_DONE} state_e;

  state_e        state_q, state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [CW-1:0] gap_q, gap_d;
  logic          abort_q, abort_d;
  logic          last_q, last_d;

  logic [NUM_REQ-1:0] req_ready_c;
  logic [7:0]         data_arr [NUM_REQ];
  logic [GW-1:0]      pick;
  logic               found;
  logic [GW-1:0]      next_g;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = bus.req_data[8*i +: 8];
    end
  end

  // Round-robin scan: first valid index starting at rr_q, wrapping mod NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[GW'((32'(rr_q) + i) % NUM_REQ)]) begin
        found = 1'b1;
        pick  = GW'((32'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  assign next_g = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    gap_d       = gap_q;
    abort_d     = 1'b0;
    last_d      = last_q;
    req_ready_c = '0;
    unique case (state_q)
      ARB: begin
        if (found) begin
          grant_d = pick;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.req_valid[grant_q] && bus.tx_ready) begin
          req_ready_c[grant_q] = 1'b1;
          tx_start_d           = 1'b1;
          tx_data_d            = data_arr[grant_q];
          last_d               = bus.req_last[grant_q];
          gap_d                = '0;
          state_d              = WAIT_BUSY;
        end else if (gap_q == CW'(GAP_TIMEOUT - 1)) begin
          // Stalled requester forfeits the grant; the next one in line goes first.
          abort_d = 1'b1;
          rr_d    = next_g;
          gap_d   = '0;
          state_d = ARB;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!bus.tx_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_ready) begin
          if (last_q) begin
            rr_d    = next_g;
            state_d = ARB;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      rr_q       <= '0;
      gap_q      <= '0;
      abort_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
      abort_q    <= abort_d;
      last_q     <= last_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q != ARB);
  assign bus.pkt_abort = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, GAP_TIMEOUT=16).
// Requesters are modelled as per-index byte queues; uart_tx as a responder that
// drops tx_ready for a frame after each start pulse. Expected transmit order is
// either written out per directed scenario or derived from a packet-level
// round-robin model for the randomized rounds.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .GAP_TIMEOUT(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [8:0] rq [N][$];   // {last, data} still to be offered by requester i
  int gap_left [N];
  bit rand_gaps = 1'b0;
  int exp_id [$];
  logic [7:0] exp_d [$];
  int tx_cnt, abort_cnt, idle_busy_cnt;
  int rdy_cnt [N];
  int frame_min = 4;
  int frame_max = 4;
  int model_rr;

  // uart_tx responder: busy for a frame after every start pulse.
  initial bus.tx_ready = 1'b1;
  always begin
    @(negedge clk);
    if (bus.tx_start === 1'b1) begin
      @(posedge clk);
      #1 bus.tx_ready = 1'b0;
      repeat ($urandom_range(frame_max, frame_min)) @(posedge clk);
      #1 bus.tx_ready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add(input int i, input logic [7:0] d, input bit last);
    rq[i].push_back({last, d});
  endtask

  task automatic expect_tx(input int i, input logic [7:0] d);
    exp_id.push_back(i);
    exp_d.push_back(d);
  endtask

  task automatic clr();
    tx_cnt = 0; abort_cnt = 0; idle_busy_cnt = 0;
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && gap_left[i] == 0) begin
        e = rq[i][0];
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = e[7:0];
        bus.req_last[i]        = e[8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'($urandom);
        bus.req_last[i]        = 1'($urandom);
      end
      if (gap_left[i] > 0) gap_left[i]--;
    end
  endtask

  task automatic monitor();
    logic [N-1:0] rr;
    logic [N-1:0] one;
    logic [8:0]   e;
    logic [7:0]   d;
    int           id;
    one = 1;
    rr  = bus.req_ready;
    chk("ready_legal", ((rr == '0) ||
        ((rr == (one << bus.grant_id)) && bus.busy && bus.tx_ready)) ? 1 : 0, 1);
    for (int i = 0; i < N; i++) begin
      if (rr[i] === 1'b1 && rq[i].size() > 0) begin
        rdy_cnt[i]++;
        e = rq[i].pop_front();
        if (!e[8] && rq[i].size() > 0 && rand_gaps) gap_left[i] = $urandom_range(3, 0);
      end
    end
    if (bus.tx_start === 1'b1) begin
      tx_cnt++;
      idle_busy_cnt = 0;
      chk("tx_expected", (exp_d.size() != 0) ? 1 : 0, 1);
      if (exp_d.size() != 0) begin
        d  = exp_d.pop_front();
        id = exp_id.pop_front();
        chk("tx_data", bus.tx_data, d);
        chk("tx_grant", bus.grant_id, id);
      end
    end else if (bus.busy === 1'b1 && bus.tx_ready === 1'b1) begin
      idle_busy_cnt++;
    end
    if (bus.pkt_abort === 1'b1) abort_cnt++;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input int maxc);
    int c;
    bit done;
    c = 0; done = 1'b0;
    while (!done && c < maxc) begin
      step();
      c++;
      done = (bus.busy === 1'b0) && (exp_d.size() == 0) && queues_empty() && (bus.tx_ready === 1'b1);
    end
    chk("idle_reached", done, 1);
    repeat (3) step();
  endtask

  task automatic wait_tx(input int n, input int maxc);
    int c;
    c = 0;
    while (tx_cnt < n && c < maxc) begin step(); c++; end
    chk("tx_wait", (tx_cnt >= n) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_grant"}, bus.grant_id, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_abort"}, bus.pkt_abort, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
  endtask

  initial begin
    logic [8:0] tmp [N][$];
    logic [8:0] e;
    int pick, npk, len;
    bit found;

    for (int i = 0; i < N; i++) gap_left[i] = 0;
    rst = 1'b1;
    drive();
    clr();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // 1: three-byte packet from requester 0
    clr();
    add(0, 8'hA5, 0); add(0, 8'h5A, 0); add(0, 8'h0F, 1);
    expect_tx(0, 8'hA5); expect_tx(0, 8'h5A); expect_tx(0, 8'h0F);
    drive();
    run_idle(300);
    chk("t1_tx_count", tx_cnt, 3);
    chk("t1_ready0", rdy_cnt[0], 3);
    chk("t1_grant", bus.grant_id, 0);
    chk("t1_busy", bus.busy, 0);

    // 2: req1 and req2 together from rr_ptr=0, then probe rr_ptr=3
    do_reset();
    clr();
    add(1, 8'h11, 0); add(1, 8'h12, 1);
    add(2, 8'h21, 0); add(2, 8'h22, 1);
    expect_tx(1, 8'h11); expect_tx(1, 8'h12); expect_tx(2, 8'h21); expect_tx(2, 8'h22);
    drive();
    run_idle(400);
    chk("t2_tx_count", tx_cnt, 4);
    add(0, 8'hC0, 1); add(3, 8'hC3, 1);
    expect_tx(3, 8'hC3); expect_tx(0, 8'hC0);
    drive();
    run_idle(300);
    chk("t2_rr_probe_grant", bus.grant_id, 0);

    // 3: req3 arrives while req0 is mid-packet
    clr();
    add(0, 8'h31, 0); add(0, 8'h32, 0); add(0, 8'h33, 1);
    expect_tx(0, 8'h31); expect_tx(0, 8'h32); expect_tx(0, 8'h33); expect_tx(3, 8'h3A);
    drive();
    wait_tx(1, 100);
    add(3, 8'h3A, 1);
    drive();
    run_idle(400);
    chk("t3_tx_count", tx_cnt, 4);
    chk("t3_grant", bus.grant_id, 3);
    chk("t3_ready3", rdy_cnt[3], 1);

    // 4: req2 stalls after a non-last byte -> abort after GAP SEND cycles
    clr();
    add(2, 8'h41, 0);
    expect_tx(2, 8'h41);
    drive();
    run_idle(400);
    chk("t4_abort_pulses", abort_cnt, 1);
    chk("t4_tx_count", tx_cnt, 1);
    // one WAIT_DONE cycle plus GAP stalled SEND cycles
    chk("t4_gap_cycles", idle_busy_cnt, GAP + 1);
    chk("t4_busy", bus.busy, 0);
    add(1, 8'hB1, 1); add(3, 8'hB3, 1);
    expect_tx(3, 8'hB3); expect_tx(1, 8'hB1);
    drive();
    run_idle(300);
    chk("t4_rr_probe_count", tx_cnt, 3);
    chk("t4_no_second_abort", abort_cnt, 1);

    // 5: reset during WAIT_DONE of byte 2
    clr();
    add(0, 8'h51, 0); add(0, 8'h52, 0); add(0, 8'h53, 1);
    expect_tx(0, 8'h51); expect_tx(0, 8'h52); expect_tx(0, 8'h53);
    drive();
    wait_tx(2, 200);
    begin
      int c;
      c = 0;
      while (bus.tx_ready !== 1'b0 && c < 20) begin step(); c++; end
      chk("t5_frame_seen", bus.tx_ready, 0);
    end
    step();
    chk("t5_in_packet", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    step(); step();
    rst = 1'b0;
    run_idle(300);
    chk("t5_tx_count", tx_cnt, 3);
    chk("t5_grant", bus.grant_id, 0);

    // 6: back-to-back packets from req0 alone, then alternating with req1
    clr();
    add(0, 8'h61, 0); add(0, 8'h62, 1); add(0, 8'h63, 1);
    expect_tx(0, 8'h61); expect_tx(0, 8'h62); expect_tx(0, 8'h63);
    drive();
    run_idle(400);
    chk("t6_solo_count", tx_cnt, 3);
    chk("t6_solo_grant", bus.grant_id, 0);
    add(0, 8'h71, 1); add(0, 8'h72, 1);
    expect_tx(0, 8'h71); expect_tx(1, 8'h81); expect_tx(0, 8'h72); expect_tx(1, 8'h82);
    drive();
    step(); step();
    add(1, 8'h81, 1); add(1, 8'h82, 1);
    drive();
    run_idle(400);
    chk("t6_alt_count", tx_cnt, 7);
    chk("t6_alt_grant", bus.grant_id, 1);
    chk("t6_no_abort", abort_cnt, 0);

    // Randomized rounds against a packet-level round-robin model
    do_reset();
    model_rr  = 0;
    rand_gaps = 1'b1;
    frame_min = 2;
    frame_max = 6;
    for (int r = 0; r < 6; r++) begin
      clr();
      for (int i = 0; i < N; i++) begin
        npk = $urandom_range(3, 0);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) add(i, 8'($urandom), (b == len - 1));
        end
      end
      for (int i = 0; i < N; i++) tmp[i] = rq[i];
      forever begin
        found = 1'b0;
        pick  = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && tmp[(model_rr + k) % N].size() > 0) begin
            found = 1'b1;
            pick  = (model_rr + k) % N;
          end
        end
        if (!found) break;
        do begin
          e = tmp[pick].pop_front();
          expect_tx(pick, e[7:0]);
        end while (!e[8]);
        model_rr = (pick + 1) % N;
      end
      drive();
      run_idle(5000);
      chk("rand_drained", exp_d.size(), 0);
      chk("rand_no_abort", abort_cnt, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
